activation_pool: RTL and testbench

- Streaming post-processing stage directly downstream of the convolver; consumes the signed MAC result stream one sample per valid cycle.
- Applies optional ReLU, then arithmetic right-shift requantization with saturation to WID_OUT.
- Applies optional 2x2 stride-2 max pooling using an internal half-row buffer.
- Emits a narrowed valid-qualified stream toward the output writer; no backpressure, matching the convolver's free-running output.

---
 rtl/activation_pool.sv | 139 +++++++++++++
 tb/tb_activation_pool.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/activation_pool.sv
// Purpose : ReLU + shift/saturate requantization with optional 2x2 stride-2 max pool.
// Latency : 2 cycles in_valid -> out_valid (bypass, or from the odd-column/odd-row sample when pooling).
// Backpressure: none; accepts one sample per cycle and emits free-running valid pulses.
//
// Ports:
//   clk, rst             rising-edge clock, async active-low reset
//   frame_reset          synchronous clear of counters/pipeline (wins over in_valid)
//   row_length           conv outputs per row, 2..MAX_ROW (0 encodes MAX_ROW)
//   relu_en, pool_en     clamp negatives to 0 / enable 2x2 max pool
//   shift_amt            arithmetic right shift before saturation
//   in_valid, in_data    signed MAC sample stream
//   out_valid, out_data  signed WID_OUT result stream, one-cycle pulses
//   out_row_end          marks the last output of an output row
module activation_pool #(
   parameter int WID_IN  = 32,
   parameter int WID_OUT = 16,
   parameter int MAX_ROW = 256,
   parameter int ADDR_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_reset,
   input  logic [ADDR_W-1:0]         row_length,
   input  logic                      relu_en,
   input  logic                      pool_en,
   input  logic [4:0]                shift_amt,
   input  logic                      in_valid,
   input  logic signed [WID_IN-1:0]  in_data,
   output logic                      out_valid,
   output logic signed [WID_OUT-1:0] out_data,
   output logic                      out_row_end
);

   localparam int DEPTH = MAX_ROW / 2;

   // Saturation bounds expressed at input width so the compare stays signed.
   localparam logic signed [WID_IN-1:0] SAT_MAX =
      {{(WID_IN-WID_OUT+1){1'b0}}, {(WID_OUT-1){1'b1}}};
   localparam logic signed [WID_IN-1:0] SAT_MIN =
      {{(WID_IN-WID_OUT+1){1'b1}}, {(WID_OUT-1){1'b0}}};

   // ---------------- stage 1: relu, shift, saturate ----------------
   logic signed [WID_IN-1:0]  relu_x;
   logic signed [WID_IN-1:0]  shift_y;
   logic signed [WID_OUT-1:0] sat_q;
   logic                      s1_valid;
   logic signed [WID_OUT-1:0] s1_q;

   always_comb begin
      relu_x  = (relu_en && in_data[WID_IN-1]) ? '0 : in_data;
      // >>> on a signed operand sign-fills, so very large shifts settle at 0 or -1.
      shift_y = relu_x >>> shift_amt;
      if (shift_y > SAT_MAX)
         sat_q = SAT_MAX[WID_OUT-1:0];
      else if (shift_y < SAT_MIN)
         sat_q = SAT_MIN[WID_OUT-1:0];
      else
         sat_q = shift_y[WID_OUT-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         s1_valid <= in_valid && !frame_reset;
         s1_q     <= sat_q;
      end
   end

   // ---------------- stage 2: column/row tracking and pooling ----------------
   logic [ADDR_W-1:0]         col;
   logic                      row_par;
   logic signed [WID_OUT-1:0] h_hold;
   logic signed [WID_OUT-1:0] pool_buf [DEPTH];

   logic [ADDR_W-1:0]         last_col;
   logic [ADDR_W-1:0]         last_pair;
   logic                      col_last;
   logic signed [WID_OUT-1:0] hmax;
   logic signed [WID_OUT-1:0] buf_rd;
   logic signed [WID_OUT-1:0] pmax;
   logic                      s2_go;

   always_comb begin
      // row_length of 0 wraps to MAX_ROW-1 here, giving the full-size row.
      last_col  = row_length - 1'b1;
      // Last column that closes a horizontal pair; drops the orphan column on odd rows.
      last_pair = last_col - ADDR_W'(row_length[0]);
      col_last  = (col == last_col);
      hmax      = (s1_q > h_hold) ? s1_q : h_hold;
      buf_rd    = pool_buf[col[ADDR_W-1:1]];
      pmax      = (buf_rd > hmax) ? buf_rd : hmax;
      s2_go     = s1_valid && !frame_reset;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col         <= '0;
         row_par     <= 1'b0;
         h_hold      <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_row_end <= 1'b0;
      end else if (frame_reset) begin
         col         <= '0;
         row_par     <= 1'b0;
         h_hold      <= '0;
         out_valid   <= 1'b0;
         out_row_end <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         out_row_end <= 1'b0;
         if (s1_valid) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last)
               row_par <= ~row_par;
            if (!pool_en) begin
               out_valid   <= 1'b1;
               out_data    <= s1_q;
               out_row_end <= col_last;
            end else if (!col[0]) begin
               h_hold <= s1_q;
            end else if (row_par) begin
               out_valid   <= 1'b1;
               out_data    <= pmax;
               out_row_end <= (col == last_pair);
            end
         end
      end
   end

   // Half-row buffer: written on even rows, consumed on the following odd row.
   always_ff @(posedge clk) begin
      if (s2_go && pool_en && col[0] && !row_par)
         pool_buf[col[ADDR_W-1:1]] <= hmax;
   end

endmodule

// File: tb/tb_activation_pool.sv
module tb_activation_pool;

   logic               clk = 1'b0;
   logic               rst;
   logic               frame_reset;
   logic [7:0]         row_length;
   logic               relu_en;
   logic               pool_en;
   logic [4:0]         shift_amt;
   logic               in_valid;
   logic signed [31:0] in_data;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               out_row_end;

   always #5 clk = ~clk;

   activation_pool #(.WID_IN(32), .WID_OUT(16), .MAX_ROW(256), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .frame_reset(frame_reset), .row_length(row_length),
      .relu_en(relu_en), .pool_en(pool_en), .shift_amt(shift_amt),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .out_row_end(out_row_end)
   );

   typedef struct {
      int data;
      int row_end;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got data %0d row_end %0d, expected no output",
                     out_data, out_row_end);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", int'(out_data), e.data);
            check("out_row_end", int'(out_row_end), e.row_end);
            check("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic send(int d, bit v = 1'b1, bit fr = 1'b0);
      in_valid    = v;
      in_data     = d;
      frame_reset = fr;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      frame_reset = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) send(0, 1'b0);
   endtask

   // Output produced by the next sent sample appears two cycles later.
   task automatic expect_out(int d, int re);
      exp_t e;
      e.data    = d;
      e.row_end = re;
      e.cyc     = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic cfg(int len, bit relu, bit pool, int sh);
      idle(3);
      row_length = len[7:0];
      relu_en    = relu;
      pool_en    = pool;
      shift_amt  = sh[4:0];
      send(0, 1'b0, 1'b1);
   endtask

   task automatic pool_frame(int gap);
      int row0[4] = '{1, 5, -3, 2};
      int row1[4] = '{4, 2, 7, -8};
      for (int i = 0; i < 4; i++) begin
         send(row0[i]);
         idle(gap);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) expect_out(5, 0);
         if (i == 3) expect_out(7, 1);
         send(row1[i]);
         idle(gap);
      end
   endtask

   initial begin
      rst         = 1'b0;
      frame_reset = 1'b0;
      row_length  = 8'd4;
      relu_en     = 1'b0;
      pool_en     = 1'b0;
      shift_amt   = 5'd0;
      in_valid    = 1'b0;
      in_data     = 0;
      #12;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      check("reset_out_row_end", int'(out_row_end), 0);
      #5 rst = 1'b1;
      @(posedge clk);
      #1;

      // Pool with ReLU, back-to-back
      cfg(4, 1'b1, 1'b1, 0);
      pool_frame(0);

      // Bypass: saturation and shift
      cfg(4, 1'b0, 1'b0, 0);
      expect_out(32767, 0);  send(40000);
      expect_out(-32768, 0); send(-40000);
      cfg(4, 1'b0, 1'b0, 4);
      expect_out(16, 0);     send(256);
      cfg(4, 1'b0, 1'b0, 2);
      expect_out(-5, 0);     send(-17);
      expect_out(2, 0);      send(8);
      expect_out(0, 0);      send(3);
      expect_out(-1, 1);     send(-1);
      cfg(4, 1'b0, 1'b0, 31);
      expect_out(-1, 0);     send(-40000);
      expect_out(0, 0);      send(40000);

      // Odd row length: orphan column dropped
      cfg(3, 1'b0, 1'b1, 0);
      send(-9); send(-2); send(100);
      send(-7);
      expect_out(-2, 1);     send(-4);
      send(50);

      // Gapped input
      cfg(4, 1'b1, 1'b1, 0);
      pool_frame(1);

      // frame_reset mid-row with in_valid high
      cfg(4, 1'b1, 1'b1, 0);
      send(1); send(5); send(-3); send(2);
      send(4); send(2);
      send(99, 1'b1, 1'b1);
      pool_frame(0);

      // Async reset while an output is presented
      cfg(4, 1'b0, 1'b0, 0);
      send(123);
      @(posedge clk);
      #2;
      check("pre_reset_out_valid", int'(out_valid), 1);
      check("pre_reset_out_data", int'(out_data), 123);
      rst = 1'b0;
      #1;
      check("async_out_valid", int'(out_valid), 0);
      check("async_out_data", int'(out_data), 0);
      check("async_out_row_end", int'(out_row_end), 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      cfg(4, 1'b1, 1'b1, 0);
      pool_frame(0);

      idle(6);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
